// File: rtl/ahb_slave_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter_if
// Bundles the signals between several AHB masters and the slave-port arbiter.
//   hreq        [CHANNEL_NUM]  per-master bus request
//   hlock       [CHANNEL_NUM]  per-master locked-transfer flag
//   hready                     slave transfer-complete (ends the data phase)
//   sel         [CHANNEL_NUM]  one-hot address-phase select, zero when idle
//   data_sel    [CHANNEL_NUM]  one-hot data-phase select (sel, one transfer late)
//   grant_valid                sel is non-zero
//   master_id   [log2(N)]      binary index of the bit set in sel, zero when idle
// Modports: master = request side (drives hreq/hlock/hready),
//           slave  = arbiter side (drives the select outputs).
// ---------------------------------------------------------------------------
interface ahb_slave_arbiter_if #(
  parameter int CHANNEL_NUM = 4
);
  localparam int IDW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  logic [CHANNEL_NUM-1:0] hreq;
  logic [CHANNEL_NUM-1:0] hlock;
  logic                   hready;
  logic [CHANNEL_NUM-1:0] sel;
  logic [CHANNEL_NUM-1:0] data_sel;
  logic                   grant_valid;
  logic [IDW-1:0]         master_id;

  modport master (
    output hreq, hlock, hready,
    input  sel, data_sel, grant_valid, master_id
  );

  modport slave (
    input  hreq, hlock, hready,
    output sel, data_sel, grant_valid, master_id
  );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter
// Round-robin arbiter granting one AHB slave port to one of CHANNEL_NUM
// masters. An unlocked owner keeps the grant for at most MAX_HOLD completed
// transfers while others wait; a locked owner keeps it indefinitely.
// Ports:
//   HCLK     sole clock, rising edge
//   HRESETn  synchronous, active-low reset
//   bus      ahb_slave_arbiter_if.slave (hreq/hlock/hready in,
//            sel/data_sel/grant_valid/master_id out, all registered)
// Parameters:
//   CHANNEL_NUM  number of masters (2..16)
//   MAX_HOLD     transfer quota for an unlocked owner (1..255)
// ---------------------------------------------------------------------------
module ahb_slave_arbiter #(
  parameter int CHANNEL_NUM = 4,
  parameter int MAX_HOLD    = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_slave_arbiter_if.slave  bus
);
  localparam int             IDW      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam logic [7:0]     HOLD_MAX = 8'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(CHANNEL_NUM - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q;
  logic [IDW-1:0]         rr_ptr_q;      // last owner; equals current owner while OWNED
  logic [7:0]             hold_q;
  logic [CHANNEL_NUM-1:0] sel_q;
  logic [CHANNEL_NUM-1:0] data_sel_q;
  logic                   grant_valid_q;
  logic [IDW-1:0]         master_id_q;

  logic                   arb_point;
  logic                   found_d;
  logic [IDW-1:0]         owner_d;
  logic [CHANNEL_NUM-1:0] sel_d;

  // Arbitration happens when idle, when the owner stops requesting, or when an
  // unlocked owner has used up its quota. Lock only beats the quota; an owner
  // that drops its request gives the bus up even if hlock is still high.
  always_comb begin
    arb_point = (state_q == IDLE)
             || !bus.hreq[rr_ptr_q]
             || (!bus.hlock[rr_ptr_q] && (hold_q == HOLD_MAX));
  end

  // Search rr_ptr+1, rr_ptr+2, ... wrapping; the last candidate examined is
  // rr_ptr itself, so the current owner only wins when nobody else asks.
  always_comb begin
    int             pos;
    logic [IDW-1:0] idx;
    found_d = 1'b0;
    owner_d = rr_ptr_q;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      pos = (int'(rr_ptr_q) + k) % CHANNEL_NUM;
      idx = IDW'(pos);
      if (!found_d && bus.hreq[idx]) begin
        found_d = 1'b1;
        owner_d = idx;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_onehot
    assign sel_d[gi] = (owner_d == IDW'(gi));
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= LAST_IDX;
      hold_q        <= 8'd0;
      sel_q         <= '0;
      data_sel_q    <= '0;
      grant_valid_q <= 1'b0;
      master_id_q   <= '0;
    end else if (bus.hready) begin
      // Data phase follows the address phase by exactly one accepted transfer.
      data_sel_q <= sel_q;
      if (arb_point) begin
        hold_q <= 8'd0;
        if (found_d) begin
          state_q       <= OWNED;
          rr_ptr_q      <= owner_d;
          sel_q         <= sel_d;
          grant_valid_q <= 1'b1;
          master_id_q   <= owner_d;
        end else begin
          state_q       <= IDLE;
          sel_q         <= '0;
          grant_valid_q <= 1'b0;
          master_id_q   <= '0;
        end
      end else if (hold_q != HOLD_MAX) begin
        hold_q <= hold_q + 8'd1;
      end
    end
  end

  assign bus.sel         = sel_q;
  assign bus.data_sel    = data_sel_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.master_id   = master_id_q;
endmodule
